// File: rtl/acc_buffer.sv
// acc_buffer: partial-sum accumulation buffer. Rows of ARRAY_DIM signed lane
// sums are overwritten or read-modify-write accumulated through a two-stage
// pipeline, then drained in address order over a valid/ready stream.
module acc_buffer #(
  parameter int ARRAY_DIM = 16,
  parameter int ACC_W     = 32,
  parameter int DEPTH     = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       acc_enable,
  input  logic                       acc_clear,
  input  logic [ADDR_W-1:0]          acc_addr,
  input  logic [ARRAY_DIM*ACC_W-1:0] pe_acc_in,
  input  logic                       rd_start,
  input  logic [ADDR_W:0]            rd_count,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [ARRAY_DIM*ACC_W-1:0] rd_data,
  output logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_last,
  output logic                       rd_busy,
  output logic                       ovf,
  output logic                       err,
  input  logic                       flag_clr
);

  localparam int ROW_W = ARRAY_DIM * ACC_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

  state_t               state;
  logic [ROW_W-1:0]     mem [DEPTH];
  logic [ROW_W-1:0]     rdq;

  logic                 s1_valid;
  logic                 s1_clear;
  logic [ADDR_W-1:0]    s1_addr;
  logic [ROW_W-1:0]     s1_in;

  logic [ROW_W-1:0]     new_row;
  logic [ARRAY_DIM-1:0] lane_ovf;
  logic                 ovf_set;

  logic [ADDR_W:0]      rd_ptr;
  logic [ADDR_W:0]      cnt;
  logic [ADDR_W-1:0]    last_addr;
  logic                 rdq_dvalid;
  logic [ADDR_W-1:0]    rdq_addr;
  logic                 sk_valid;
  logic [ROW_W-1:0]     sk_data;
  logic [ADDR_W-1:0]    sk_addr;

  logic                 acc_take;
  logic                 acc_drop;
  logic                 start_ok;
  logic [ADDR_W:0]      sat_count;
  logic                 pop;
  logic [1:0]           occ;
  logic                 drain_ren;
  logic                 ren;
  logic [ADDR_W-1:0]    raddr;

  // Per-lane overwrite-or-add of the stage-1 row, with signed overflow detect
  always_comb begin
    new_row  = '0;
    lane_ovf = '0;
    for (int i = 0; i < ARRAY_DIM; i++) begin
      new_row[i*ACC_W +: ACC_W] = s1_clear ? s1_in[i*ACC_W +: ACC_W]
                                           : rdq[i*ACC_W +: ACC_W] + s1_in[i*ACC_W +: ACC_W];
      lane_ovf[i] = (rdq[i*ACC_W+ACC_W-1] == s1_in[i*ACC_W+ACC_W-1]) &&
                    (new_row[i*ACC_W+ACC_W-1] != rdq[i*ACC_W+ACC_W-1]);
    end
  end

  // Read-port arbitration and drain prefetch control; entries in flight
  // (output, skid, read register) never exceed what output + skid can hold
  always_comb begin
    acc_take  = acc_enable && !rd_busy;
    acc_drop  = acc_enable && rd_busy;
    start_ok  = (state == IDLE) && rd_start && (rd_count != '0) && !s1_valid;
    sat_count = (rd_count > DEPTH_CNT) ? DEPTH_CNT : rd_count;
    ovf_set   = s1_valid && !s1_clear && (|lane_ovf);
    pop       = rd_valid && rd_ready;
    occ       = 2'(rd_valid) + 2'(sk_valid) + 2'(rdq_dvalid);
    drain_ren = (state == FETCH) ||
                ((state == STREAM) && (rd_ptr < cnt) && ((occ - 2'(pop)) <= 2'd1));
    ren       = acc_take || drain_ren;
    raddr     = (state == IDLE) ? acc_addr : rd_ptr[ADDR_W-1:0];
  end

  // Storage: stage-1 write plus synchronous read with forwarding of the
  // in-flight write so back-to-back beats and early drains see fresh data
  always_ff @(posedge clk) begin
    if (s1_valid && !rst)
      mem[s1_addr] <= new_row;
    if (ren)
      rdq <= (s1_valid && (s1_addr == raddr)) ? new_row : mem[raddr];
  end

  // Accumulate stage-0 capture and the sticky overflow / collision flags
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      s1_valid <= acc_take;
      s1_clear <= acc_clear;
      s1_addr  <= acc_addr;
      s1_in    <= pe_acc_in;
      if (ovf_set)
        ovf <= 1'b1;
      else if (flag_clr)
        ovf <= 1'b0;
      if (acc_drop)
        err <= 1'b1;
      else if (flag_clr)
        err <= 1'b0;
    end
  end

  // Drain FSM with prefetch register, one-entry skid and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_busy    <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_addr    <= '0;
      rd_last    <= 1'b0;
      sk_valid   <= 1'b0;
      rdq_dvalid <= 1'b0;
      rd_ptr     <= '0;
      cnt        <= '0;
      last_addr  <= '0;
    end else begin
      rdq_dvalid <= drain_ren;
      rdq_addr   <= rd_ptr[ADDR_W-1:0];
      if (drain_ren)
        rd_ptr <= rd_ptr + 1'b1;
      case (state)
        IDLE: begin
          if (start_ok) begin
            state     <= FETCH;
            rd_busy   <= 1'b1;
            cnt       <= sat_count;
            last_addr <= ADDR_W'(sat_count - 1'b1);
            rd_ptr    <= '0;
          end
        end
        FETCH: begin
          state <= STREAM;
        end
        STREAM: begin
          if (!rd_valid || pop) begin
            if (sk_valid) begin
              rd_valid <= 1'b1;
              rd_data  <= sk_data;
              rd_addr  <= sk_addr;
              rd_last  <= (sk_addr == last_addr);
              sk_valid <= rdq_dvalid;
              sk_data  <= rdq;
              sk_addr  <= rdq_addr;
            end else if (rdq_dvalid) begin
              rd_valid <= 1'b1;
              rd_data  <= rdq;
              rd_addr  <= rdq_addr;
              rd_last  <= (rdq_addr == last_addr);
            end else begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end
          end else if (rdq_dvalid) begin
            sk_valid <= 1'b1;
            sk_data  <= rdq;
            sk_addr  <= rdq_addr;
          end
          if (pop && rd_last) begin
            state   <= IDLE;
            rd_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_buffer.sv
// tb_acc_buffer: directed scoreboard bench for acc_buffer. Drains push the
// expected beats into a queue; a negedge monitor pops and compares on every
// handshake and checks that stalled beats hold steady.
module tb_acc_buffer;

  localparam int ARRAY_DIM = 16;
  localparam int ACC_W     = 32;
  localparam int DEPTH     = 1024;
  localparam int ADDR_W    = 10;
  localparam int ROW_W     = ARRAY_DIM * ACC_W;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 acc_enable;
  logic                 acc_clear;
  logic [ADDR_W-1:0]    acc_addr;
  logic [ROW_W-1:0]     pe_acc_in;
  logic                 rd_start;
  logic [ADDR_W:0]      rd_count;
  logic                 rd_valid;
  logic                 rd_ready;
  logic [ROW_W-1:0]     rd_data;
  logic [ADDR_W-1:0]    rd_addr;
  logic                 rd_last;
  logic                 rd_busy;
  logic                 ovf;
  logic                 err;
  logic                 flag_clr;

  typedef struct {
    logic [ROW_W-1:0]  data;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_t;

  beat_t            exp_q[$];
  logic [ROW_W-1:0] exp_mem [8];
  int               checks   = 0;
  int               errors   = 0;
  int               hs_count = 0;
  int               base;

  logic              stall_prev = 1'b0;
  logic [ROW_W-1:0]  saved_data;
  logic [ADDR_W:0]   saved_tag;

  acc_buffer #(
    .ARRAY_DIM(ARRAY_DIM), .ACC_W(ACC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst),
    .acc_enable(acc_enable), .acc_clear(acc_clear), .acc_addr(acc_addr),
    .pe_acc_in(pe_acc_in),
    .rd_start(rd_start), .rd_count(rd_count),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_addr(rd_addr), .rd_last(rd_last), .rd_busy(rd_busy),
    .ovf(ovf), .err(err), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  // Watchdog so a wedged design still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [ROW_W-1:0] act,
                             input logic [ROW_W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [ROW_W-1:0] fill(input logic [ACC_W-1:0] v);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ARRAY_DIM; i++) r[i*ACC_W +: ACC_W] = v;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] mul(input int k);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < ARRAY_DIM; i++) r[i*ACC_W +: ACC_W] = ACC_W'(i * k);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] lane_row(input int lane, input logic [ACC_W-1:0] v);
    logic [ROW_W-1:0] r;
    r = '0;
    r[lane*ACC_W +: ACC_W] = v;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic clr, input logic [ADDR_W-1:0] addr,
                               input logic [ROW_W-1:0] row);
    acc_enable = 1'b1;
    acc_clear  = clr;
    acc_addr   = addr;
    pe_acc_in  = row;
    @(posedge clk);
    #1;
    acc_enable = 1'b0;
    acc_clear  = 1'b0;
  endtask

  task automatic startDrain(input int count);
    idle(2);
    for (int a = 0; a < count; a++)
      exp_q.push_back('{data: exp_mem[a], addr: ADDR_W'(a), last: (a == count - 1)});
    rd_start = 1'b1;
    rd_count = (ADDR_W+1)'(count);
    @(posedge clk);
    #1;
    rd_start = 1'b0;
    checkOutput("busy_after_start", ROW_W'(rd_busy), ROW_W'(1));
  endtask

  task automatic waitDrainDone();
    for (int i = 0; i < 100 && rd_busy; i++) idle(1);
    checkOutput("drain_done", ROW_W'(rd_busy), ROW_W'(0));
    checkOutput("queue_empty", ROW_W'(exp_q.size()), ROW_W'(0));
  endtask

  // Monitor: compare each handshaken beat against the scoreboard queue and
  // require stalled beats to hold valid, data, address and last
  always @(negedge clk) begin
    beat_t b;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checkOutput("stall_valid", ROW_W'(rd_valid), ROW_W'(1));
        checkOutput("stall_data", rd_data, saved_data);
        checkOutput("stall_addr_last", ROW_W'({rd_last, rd_addr}), ROW_W'(saved_tag));
      end
      if (rd_valid && rd_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got addr %0d, expected no beat", rd_addr);
        end else begin
          b = exp_q.pop_front();
          checkOutput("beat_addr", ROW_W'(rd_addr), ROW_W'(b.addr));
          checkOutput("beat_last", ROW_W'(rd_last), ROW_W'(b.last));
          checkOutput("beat_data", rd_data, b.data);
        end
      end
      stall_prev = rd_valid && !rd_ready;
      saved_data = rd_data;
      saved_tag  = {rd_last, rd_addr};
    end
  end

  // Directed test sequence
  initial begin
    int pattern [7];
    pattern = '{1, 0, 0, 1, 1, 0, 1};
    rst = 1'b1; acc_enable = 1'b0; acc_clear = 1'b0; acc_addr = '0; pe_acc_in = '0;
    rd_start = 1'b0; rd_count = '0; rd_ready = 1'b0; flag_clr = 1'b0;
    idle(3);
    rst = 1'b0;

    checkOutput("rst_rd_valid", ROW_W'(rd_valid), ROW_W'(0));
    checkOutput("rst_rd_data", rd_data, '0);
    checkOutput("rst_rd_addr", ROW_W'(rd_addr), ROW_W'(0));
    checkOutput("rst_rd_last", ROW_W'(rd_last), ROW_W'(0));
    checkOutput("rst_rd_busy", ROW_W'(rd_busy), ROW_W'(0));
    checkOutput("rst_ovf", ROW_W'(ovf), ROW_W'(0));
    checkOutput("rst_err", ROW_W'(err), ROW_W'(0));

    // Entries 0..7 start cleared so every drained row is known
    for (int a = 0; a < 8; a++) begin
      applyStimulus(1'b1, ADDR_W'(a), '0);
      exp_mem[a] = '0;
    end

    // Clear to 1 then three spaced adds of 2 -> 7 per lane
    applyStimulus(1'b1, 10'd5, fill(32'd1));
    idle(2);
    applyStimulus(1'b0, 10'd5, fill(32'd2));
    idle(2);
    applyStimulus(1'b0, 10'd5, fill(32'd2));
    idle(2);
    applyStimulus(1'b0, 10'd5, fill(32'd2));
    exp_mem[5] = fill(32'd7);
    rd_ready = 1'b1;
    startDrain(6);
    checkOutput("latency_valid_k", ROW_W'(rd_valid), ROW_W'(0));
    idle(1);
    checkOutput("latency_valid_k1", ROW_W'(rd_valid), ROW_W'(0));
    idle(1);
    checkOutput("latency_valid_k2", ROW_W'(rd_valid), ROW_W'(1));
    waitDrainDone();

    // Back-to-back bypass: 10+20+30, clear 4, add -1 -> 3; lane i*100 x3 -> i*300
    applyStimulus(1'b1, 10'd0, fill(32'd10));
    applyStimulus(1'b0, 10'd0, fill(32'd20));
    applyStimulus(1'b0, 10'd0, fill(32'd30));
    applyStimulus(1'b1, 10'd0, fill(32'd4));
    applyStimulus(1'b0, 10'd0, fill(32'hFFFF_FFFF));
    applyStimulus(1'b1, 10'd1, mul(100));
    applyStimulus(1'b0, 10'd1, mul(100));
    applyStimulus(1'b0, 10'd1, mul(100));
    exp_mem[0] = fill(32'd3);
    exp_mem[1] = mul(300);
    startDrain(2);
    waitDrainDone();

    // Overflow wrap on lane 3: 0x7FFFFFFF + 1 -> 0x80000000
    applyStimulus(1'b1, 10'd3, lane_row(3, 32'h7FFF_FFFF));
    applyStimulus(1'b0, 10'd3, lane_row(3, 32'd1));
    checkOutput("ovf_after_clear", ROW_W'(ovf), ROW_W'(0));
    idle(1);
    checkOutput("ovf_after_add", ROW_W'(ovf), ROW_W'(1));
    exp_mem[3] = lane_row(3, 32'h8000_0000);
    flag_clr = 1'b1;
    idle(1);
    flag_clr = 1'b0;
    checkOutput("ovf_cleared", ROW_W'(ovf), ROW_W'(0));

    // flag_clr at the same edge as a new overflow: set wins
    applyStimulus(1'b1, 10'd6, lane_row(3, 32'h7FFF_FFFF));
    applyStimulus(1'b0, 10'd6, lane_row(3, 32'd1));
    flag_clr = 1'b1;
    idle(1);
    flag_clr = 1'b0;
    checkOutput("ovf_set_wins", ROW_W'(ovf), ROW_W'(1));
    exp_mem[6] = lane_row(3, 32'h8000_0000);
    flag_clr = 1'b1;
    idle(1);
    flag_clr = 1'b0;
    checkOutput("ovf_cleared2", ROW_W'(ovf), ROW_W'(0));

    // Drain backpressure with ready pattern 1,0,0,1,1,0,1
    rd_ready = 1'b0;
    startDrain(4);
    for (int i = 0; i < 10 && !rd_valid; i++) idle(1);
    checkOutput("bp_first_valid", ROW_W'(rd_valid), ROW_W'(1));
    base = hs_count;
    for (int i = 0; i < 7; i++) begin
      rd_ready = pattern[i][0];
      idle(1);
    end
    rd_ready = 1'b1;
    waitDrainDone();
    checkOutput("bp_handshakes", ROW_W'(hs_count - base), ROW_W'(4));

    // Busy collision: accumulate and rd_start during a stalled drain
    rd_ready = 1'b0;
    startDrain(3);
    rd_start = 1'b1;
    rd_count = 11'd1;
    applyStimulus(1'b1, 10'd2, fill(32'd99));
    rd_start = 1'b0;
    checkOutput("err_on_collision", ROW_W'(err), ROW_W'(1));
    checkOutput("busy_during_collision", ROW_W'(rd_busy), ROW_W'(1));
    base = hs_count;
    rd_ready = 1'b1;
    waitDrainDone();
    checkOutput("collision_handshakes", ROW_W'(hs_count - base), ROW_W'(3));
    flag_clr = 1'b1;
    idle(1);
    flag_clr = 1'b0;
    checkOutput("err_cleared", ROW_W'(err), ROW_W'(0));

    // Reset after beat 1 of an 8-beat drain, then restart from address 0
    rd_ready = 1'b1;
    startDrain(8);
    base = hs_count;
    for (int i = 0; i < 20 && (hs_count - base) < 2; i++) idle(1);
    checkOutput("mid_drain_beats", ROW_W'(hs_count - base), ROW_W'(2));
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q.delete();
    checkOutput("rst_mid_valid", ROW_W'(rd_valid), ROW_W'(0));
    checkOutput("rst_mid_busy", ROW_W'(rd_busy), ROW_W'(0));
    startDrain(2);
    waitDrainDone();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_buffer.md
# acc_buffer

Partial-sum accumulation buffer on the receive side of the PE controller's accumulator interface. Each enabled beat from the controller either overwrites or read-modify-write adds a full row of ARRAY_DIM 32-bit lane sums at `acc_addr`. After a layer finishes, a valid/ready stream port drains the stored sums in address order to the downstream requantize/writeback logic.

## Interface
- `ARRAY_DIM`, 16: lanes per entry (PE array columns).
- `ACC_W`, 32: lane accumulator width, two's complement.
- `DEPTH`, 1024: entries.
- `ADDR_W`, 10: address width; DEPTH = 2^ADDR_W.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: **one clock; reset is synchronous and active-high**.
- `acc_enable` in 1: accumulate beat valid.
- `acc_clear` in 1: with `acc_enable`, overwrite instead of add. Ignored when `acc_enable`=0.
- `acc_addr` in ADDR_W: target entry.
- `pe_acc_in` in ARRAY_DIM*ACC_W: lane values; lane i is bits [i*ACC_W +: ACC_W].
- `rd_start` in 1: pulse that starts a drain.
- `rd_count` in ADDR_W+1: entries to drain, 1..DEPTH, sampled with `rd_start`.
- `rd_valid` out 1: stream beat valid.
- `rd_ready` in 1: downstream accept.
- `rd_data` out ARRAY_DIM*ACC_W: entry contents.
- `rd_addr` out ADDR_W: address of the current beat.
- `rd_last` out 1: final beat of the drain.
- `rd_busy` out 1: drain in progress.
- `ovf` out 1: sticky; set when any lane add overflows as signed.
- `err` out 1: sticky; set when an accumulate beat arrives while `rd_busy`.
- `flag_clr` in 1: clears `ovf` and `err`.

## Operation
- Storage is a 1R1W synchronous-read array of DEPTH x (ARRAY_DIM*ACC_W). Contents are not reset. Software or the controller must clear each entry before accumulating into it.
- Accumulate pipeline:
  - Stage 0 (edge k): sample `acc_enable`, `acc_clear`, `acc_addr` and `pe_acc_in`, and issue the read of `acc_addr`.
  - Stage 1 (edge k+1): write the new value to the same address.
  - New value, per lane: `clear` ? `in` : `old + in`. The sum is ACC_W bits and wraps modulo 2^ACC_W.
  - Lane overflow: both operands have the same sign and the result's sign differs. Overflow sets `ovf`. A clear never sets `ovf`.
- Bypass: if the stage-1 address equals the address being written at the same edge, `old` comes from the in-flight write data, not from memory. One-deep bypass is enough because the read-to-write distance is one edge. Back-to-back beats to the same address, with any clear/enable mix, must produce exact sums.
- Drain FSM states:
  - IDLE → FETCH on `rd_start` with `rd_count` ≠ 0 and no stage-1 write pending. Otherwise `rd_start` is ignored and nothing changes; this includes `rd_start` while busy.
  - FETCH: issue the read of address 0, then go to STREAM.
  - STREAM: present a beat. A handshake (`rd_valid` & `rd_ready`) advances to the next address.
  - After the handshake on beat `rd_count`-1, return to IDLE.
- Stream rules:
  - `rd_data`, `rd_addr` and `rd_last` hold stable while `rd_valid` & !`rd_ready`.
  - `rd_valid` never drops without a handshake.
  - Throughput is one beat per cycle while `rd_ready`=1, using prefetch with a one-entry skid register.
- Collisions:
  - `acc_enable` while `rd_busy`: the beat is dropped, memory is unchanged, and `err` is set.
  - `flag_clr` together with a new overflow: the set wins.
- `rd_count` > DEPTH is saturated to DEPTH.

## Timing
- Reset values: `rd_valid`=0, `rd_data`=0, `rd_addr`=0, `rd_last`=0, `rd_busy`=0, `ovf`=0, `err`=0. FSM is IDLE and the stage-1 valid is cleared.
- `rst` mid-drain: the FSM returns to IDLE and `rd_valid`=0 after that edge. A pending stage-1 write is discarded.
- Accumulate latency: a beat sampled at edge k is visible to a drain read issued at edge k+1 or later.
- Drain latency: `rd_start` sampled at edge k gives `rd_busy`=1 after edge k and the first `rd_valid`=1 after edge k+2.
- `rd_busy` falls at the edge of the final handshake.
- `ovf` and `err` update at the edge that performs the offending write or drop.

## Test plan
- Clear and accumulate: addr 5 clear with all lanes 1, then three enables with 2 spaced 3 cycles apart. Drain `rd_count`=6: beat 5 reads 7 in every lane.
- Back-to-back bypass: consecutive cycles to addr 0 — clear 10, enable 20, enable 30, then clear 4, enable -1 on addr 0. Drain reads 3 in all lanes. A second run with lane i = i*100 checks lane isolation.
- Overflow wrap: clear 0x7FFFFFFF in lane 3, then add 1. Result is 0x80000000 and `ovf`=1. `flag_clr` returns `ovf` to 0.
- Drain backpressure: `rd_count`=4 with `rd_ready` pattern 1,0,0,1,1,0,1. Exactly 4 handshakes occur, addresses 0..3 in order, `rd_last` only on addr 3, and data stays stable during stalls.
- Busy collision: `acc_enable` at addr 2 during a drain. `err`=1 and entry 2 is unchanged in a later drain. `rd_start` during the drain is ignored.
- Reset mid-drain: `rst` after beat 1 of an 8-beat drain. The next cycle shows `rd_valid`=0 and `rd_busy`=0, and a new `rd_start` restarts at addr 0.
